// File: rtl/dvb_s2_symbol_feeder_pkg.sv
// Shared definitions for the DVB-S2 symbol feeder: I/Q field widths,
// feeder state encoding and the underflow counter width.
package dvb_s2_symbol_feeder_pkg;

  // I occupies the upper half of a symbol word and Q the lower half.
  localparam int I_WIDTH    = 16;
  localparam int Q_WIDTH    = 16;
  localparam int UCNT_WIDTH = 16;

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_RUN     = 1'b1
  } feeder_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UCNT_WIDTH-1:0] sat_inc(input logic [UCNT_WIDTH-1:0] v);
    return (v == {UCNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dvb_s2_symbol_feeder_symbol_fifo.sv
// Single-clock symbol FIFO with occupancy output. The head entry is presented
// combinationally; the consumer's output register acts as the read register,
// which keeps the strobe-to-symbol latency at one cycle.
module dvb_s2_symbol_feeder_symbol_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          do_wr;
  logic          do_rd;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];

  // Requests beyond capacity (write when full, read when empty) are ignored.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Next pointers and occupancy; pointers wrap modulo DEPTH by bit width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since occupancy governs validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/dvb_s2_symbol_feeder.sv
// DVB-S2 symbol feeder: buffers modulator symbols and releases one per
// symbol-rate strobe, with a prefill phase and underflow accounting.
module dvb_s2_symbol_feeder
  import dvb_s2_symbol_feeder_pkg::*;
#(
  parameter int SYMBOL_WIDTH  = I_WIDTH + Q_WIDTH,
  parameter int DEPTH         = 16,
  parameter int PREFILL_LEVEL = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [SYMBOL_WIDTH-1:0]  s_data,
  input  logic                     s_sof,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     fs_en_on_sys_clk,
  output logic [SYMBOL_WIDTH-1:0]  sym_data,
  output logic                     sym_sof,
  output logic                     sym_valid,
  output logic                     underflow,
  output logic [UCNT_WIDTH-1:0]    underflow_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int FW = SYMBOL_WIDTH + 1;

  feeder_state_t           state_q, state_d;
  logic [SYMBOL_WIDTH-1:0] sym_data_q, sym_data_d;
  logic                    sym_sof_q, sym_sof_d;
  logic                    sym_valid_q, sym_valid_d;
  logic                    underflow_q, underflow_d;
  logic [UCNT_WIDTH-1:0]   ucnt_q, ucnt_d;

  logic          fifo_wr;
  logic          fifo_rd;
  logic [FW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  // Held low through reset so upstream cannot write into a clearing buffer.
  assign s_ready = rst_n & ~fifo_full;
  assign fifo_wr = s_valid & s_ready;

  dvb_s2_symbol_feeder_symbol_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_symbol_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data ({s_sof, s_data}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign level         = fifo_level;
  assign sym_data      = sym_data_q;
  assign sym_sof       = sym_sof_q;
  assign sym_valid     = sym_valid_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = ucnt_q;

  // Strobe servicing and state transitions. Occupancy is the registered
  // value, so a same-cycle write is never visible to the strobe.
  always_comb begin
    state_d     = state_q;
    sym_data_d  = sym_data_q;
    sym_sof_d   = sym_sof_q;
    sym_valid_d = 1'b0;
    underflow_d = underflow_q;
    ucnt_d      = ucnt_q;
    fifo_rd     = 1'b0;

    case (state_q)
      ST_PREFILL: begin
        if (fs_en_on_sys_clk) begin
          sym_valid_d = 1'b1;
          sym_data_d  = '0;
          sym_sof_d   = 1'b0;
        end
        if (fifo_level >= LW'(PREFILL_LEVEL)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fs_en_on_sys_clk) begin
          sym_valid_d = 1'b1;
          if (!fifo_empty) begin
            fifo_rd    = 1'b1;
            sym_sof_d  = fifo_head[FW-1];
            sym_data_d = fifo_head[SYMBOL_WIDTH-1:0];
          end else begin
            // Starved strobe: emit silence and fall back to prefilling.
            sym_data_d  = '0;
            sym_sof_d   = 1'b0;
            underflow_d = 1'b1;
            ucnt_d      = sat_inc(ucnt_q);
            state_d     = ST_PREFILL;
          end
        end
      end
      default: state_d = ST_PREFILL;
    endcase
  end

  // State, output register and underflow accounting.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= ST_PREFILL;
      sym_data_q  <= '0;
      sym_sof_q   <= 1'b0;
      sym_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      sym_data_q  <= sym_data_d;
      sym_sof_q   <= sym_sof_d;
      sym_valid_q <= sym_valid_d;
      underflow_q <= underflow_d;
      ucnt_q      <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_dvb_s2_symbol_feeder.sv
// Scoreboard bench for dvb_s2_symbol_feeder: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_dvb_s2_symbol_feeder;

  localparam int SW    = 32;
  localparam int DEPTH = 16;
  localparam int PFL   = 8;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] s_data;
  logic          s_sof;
  logic          s_valid;
  logic          s_ready;
  logic          fs_en_on_sys_clk;
  logic [SW-1:0] sym_data;
  logic          sym_sof;
  logic          sym_valid;
  logic          underflow;
  logic [15:0]   underflow_cnt;
  logic [4:0]    level;

  dvb_s2_symbol_feeder #(
    .SYMBOL_WIDTH  (SW),
    .DEPTH         (DEPTH),
    .PREFILL_LEVEL (PFL)
  ) dut (
    .sys_clk          (sys_clk),
    .rst_n            (rst_n),
    .s_data           (s_data),
    .s_sof            (s_sof),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .fs_en_on_sys_clk (fs_en_on_sys_clk),
    .sym_data         (sym_data),
    .sym_sof          (sym_sof),
    .sym_valid        (sym_valid),
    .underflow        (underflow),
    .underflow_cnt    (underflow_cnt),
    .level            (level)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: buffered symbols as {sof, data}, a running flag,
  // underflow bookkeeping and the last symbol presented.
  logic [32:0] m_buf [$];
  logic [32:0] exp_q [$];
  bit          m_run;
  bit          m_und;
  int          m_cnt;
  logic [32:0] m_last;
  bit          mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances with the same inputs.
  task automatic cyc(input bit v, input logic [31:0] d, input bit sof, input bit stb, input bit rn);
    logic [32:0] e;
    int          pre;
    rst_n            = rn;
    s_valid          = v;
    s_data           = d;
    s_sof            = sof;
    fs_en_on_sys_clk = stb;
    @(posedge sys_clk);
    if (!rn) begin
      m_buf.delete();
      m_run  = 0;
      m_und  = 0;
      m_cnt  = 0;
      m_last = '0;
    end else begin
      pre = m_buf.size();
      if (stb) begin
        if (m_run && pre > 0) begin
          e = m_buf.pop_front();
        end else begin
          e = '0;
          if (m_run) begin
            m_und = 1;
            if (m_cnt < 16'hFFFF) m_cnt++;
            m_run = 0;
          end
        end
        exp_q.push_back(e);
        m_last = e;
      end
      if (!m_run && pre >= PFL && !(stb && m_run)) m_run = 1;
      if (v && pre != DEPTH) m_buf.push_back({sof, d});
    end
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input bit sof);
    cyc(1, d, sof, 0, 1);
  endtask
  task automatic stb();
    cyc(0, 32'h0, 0, 1, 1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 0, 1);
  endtask
  task automatic rst();
    cyc(0, 32'h0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per presented symbol and checks the
  // observable status outputs every cycle.
  always @(negedge sys_clk) begin
    logic [32:0] e;
    if (mon_en) begin
      if (sym_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sym_valid", 64'(sym_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("symbol", {31'd0, sym_sof, sym_data}, {31'd0, e});
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("missing_sym_valid", 64'(sym_valid), 64'd1);
      end
      check("held_symbol", {31'd0, sym_sof, sym_data}, {31'd0, m_last});
      check("level", 64'(level), 64'(m_buf.size()));
      check("s_ready", 64'(s_ready), 64'(rst_n && m_buf.size() != DEPTH));
      check("underflow", 64'(underflow), 64'(m_und));
      check("underflow_cnt", 64'(underflow_cnt), 64'(m_cnt));
    end
  end

  initial begin
    int p_v;
    int p_s;
    rst_n = 0; s_valid = 0; s_data = '0; s_sof = 0; fs_en_on_sys_clk = 0;
    m_run = 0; m_und = 0; m_cnt = 0; m_last = '0;
    rst();
    mon_en = 1'b1;

    // Prefill: strobe below threshold yields silence, no underflow.
    for (int i = 0; i < 7; i++) wr(32'h100 + 32'(i), i == 0);
    stb();
    wr(32'h107, 0);
    idle(2);
    for (int i = 0; i < 8; i++) stb();
    stb();

    // Ordering of a full frame with SOF on the first symbol.
    rst();
    for (int i = 0; i < 16; i++) wr(32'h0001_0002 + 32'(i) * 32'h0001_0001, i == 0);
    idle(2);
    for (int i = 0; i < 16; i++) stb();

    // Full buffer drops excess writes; reset with strobe produces nothing.
    cyc(0, 32'h0, 0, 1, 0);
    cyc(0, 32'h0, 0, 1, 0);
    for (int i = 0; i < 20; i++) wr(32'hA000 + 32'(i), 0);
    idle(2);
    for (int i = 0; i < 17; i++) stb();

    // Starvation at level 1.
    rst();
    for (int i = 0; i < 9; i++) wr(32'hB000 + 32'(i), 0);
    idle(2);
    for (int i = 0; i < 8; i++) stb();
    stb();
    stb();

    // Simultaneous write and strobe with an empty buffer in RUN.
    rst();
    for (int i = 0; i < 8; i++) wr(32'hC000 + 32'(i), 0);
    idle(2);
    for (int i = 0; i < 8; i++) stb();
    cyc(1, 32'hC0DE, 1, 1, 1);
    idle(2);

    // Mid-run reset at level 10 with a strobe held during reset.
    rst();
    for (int i = 0; i < 10; i++) wr(32'hD000 + 32'(i), 0);
    idle(2);
    cyc(0, 32'h0, 0, 1, 0);
    idle(3);

    // Randomized traffic in phases of differing write/strobe pressure.
    for (int ph = 0; ph < 12; ph++) begin
      p_v = $urandom_range(20, 90);
      p_s = $urandom_range(20, 90);
      for (int i = 0; i < 250; i++) begin
        cyc($urandom_range(0, 99) < p_v, $urandom, $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) < p_s, $urandom_range(0, 299) != 0);
      end
    end

    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
